sqrt_range_ctrl: RTL and testbench

Sequencer for the shared piecewise-linear square-root datapath in the Box-Muller chain. It accepts one unsigned value e = -2ln(u0) per transaction through a valid/ready handshake and range-reduces it to [1,2) or [2,4) with an iterative leading-one search. It then drives the combinational sqrt unit (fraction, interval select), captures its result and denormalises it into sqrt(e). It sits between the log stage and the sin/cos multiply stage.

---
 rtl/sqrt_range_ctrl.sv | 114 +++++++++++
 tb/tb_sqrt_range_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_range_ctrl.sv
// sqrt_range_ctrl: range-reduction sequencer around the shared sqrt datapath.
// Takes e (UQ6.25) on a valid/ready handshake and returns sqrt(e) (UQ3.21).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake, e_in = e (UQ6.25)
//   out_valid/out_ready  output handshake, f_out = sqrt(e) (UQ3.21)
//   sq_x_f, sq_polysel   fraction and interval select to the sqrt datapath
//   sq_y_f               sqrt datapath result (UQ2.18), combinational
module sqrt_range_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [30:0] e_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] f_out,
   output logic [30:0] sq_x_f,
   output logic        sq_polysel,
   input  logic [19:0] sq_y_f
);

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      EVAL,
      OUT
   } state_t;

   state_t             state;
   logic        [30:0] sh;
   logic        [4:0]  cnt;
   logic signed [4:0]  k;

   logic signed [5:0]  exp_s;
   logic        [22:0] t;
   logic        [24:0] t_up;
   logic        [4:0]  rsh;
   logic        [22:0] t_dn;
   logic        [23:0] f_next;

   // exponent of the leading one, -25..5, fits a 6-bit signed value
   assign exp_s = 6'sd5 - $signed({1'b0, cnt});

   assign t    = {sq_y_f, 3'b000};
   assign t_up = {2'b00, t} << k[1:0];
   assign rsh  = 5'd0 - $unsigned(k);
   assign t_dn = t >> rsh;

   always_comb begin
      f_next = {1'b0, t_dn};
      if (!k[4]) begin
         f_next = t_up[24] ? 24'hFFFFFF : t_up[23:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         f_out      <= '0;
         sq_x_f     <= '0;
         sq_polysel <= 1'b1;
         sh         <= '0;
         cnt        <= '0;
         k          <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (e_in == '0) begin
                     f_out     <= '0;
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end else begin
                     sh    <= e_in;
                     cnt   <= '0;
                     state <= NORM;
                  end
               end
            end
            NORM: begin
               if (sh[30]) begin
                  sq_x_f     <= {sh[29:0], 1'b0};
                  // odd exponent: use the [2,4) interval and drop one
                  sq_polysel <= ~exp_s[0];
                  // floor(exp/2) equals the exact half of the even-adjusted exp
                  k          <= exp_s[5:1];
                  state      <= EVAL;
               end else begin
                  sh  <= sh << 1;
                  cnt <= cnt + 5'd1;
               end
            end
            EVAL: begin
               f_out     <= f_next;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_range_ctrl.sv
// tb_sqrt_range_ctrl: bench for sqrt_range_ctrl with a real-valued
// model of the sqrt datapath, a vector table, random traffic and corner cases.
module tb_sqrt_range_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [30:0] e_in;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] f_out;
   logic [30:0] sq_x_f;
   logic        sq_polysel;
   logic [19:0] sq_y_f;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // sqrt datapath stand-in: floor(sqrt(v) * 2^18),
   // v = 1+x on [1,2) or 2*(1+x) on [2,4)
   function automatic logic [19:0] ydp(input logic [30:0] x, input logic ps);
      real v;
      v = 1.0 + real'(x) / 2147483648.0;
      if (!ps) v = 2.0 * v;
      return 20'($rtoi($sqrt(v) * 262144.0));
   endfunction

   assign sq_y_f = ydp(sq_x_f, sq_polysel);

   sqrt_range_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .e_in       (e_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .f_out      (f_out),
      .sq_x_f     (sq_x_f),
      .sq_polysel (sq_polysel),
      .sq_y_f     (sq_y_f)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // e = value/2^25; leading one at bit p gives e = m*2^(p-25), m in [1,2)
   function automatic void ref_model(input logic [30:0] e,
                                     output logic [23:0] f,
                                     output int lat,
                                     output logic [30:0] xf,
                                     output logic ps);
      int p;
      int ex;
      int kk;
      logic [63:0] w;
      logic [63:0] tt;
      f   = '0;
      lat = 0;
      xf  = '0;
      ps  = 1'b1;
      if (e == '0) return;
      p = 0;
      for (int i = 0; i < 31; i++) if (e[i]) p = i;
      lat = (30 - p) + 2;
      w   = 64'(e) << (31 - p);
      xf  = w[30:0];
      ex  = p - 25;
      ps  = ((ex % 2) == 0);
      if (!ps) ex = ex - 1;
      kk  = ex / 2;
      tt  = 64'(ydp(xf, ps)) * 64'd8;
      if (kk >= 0) begin
         tt = tt << kk;
         f  = (tt > 64'hFFFFFF) ? 24'hFFFFFF : tt[23:0];
      end else begin
         tt = tt >> (-kk);
         f  = tt[23:0];
      end
   endfunction

   // lat = rising edges after the acceptance edge until out_valid is seen;
   // 0 means out_valid is already up in the cycle right after acceptance
   task automatic txn(input logic [30:0] e, input int exp_lat,
                      input logic [23:0] exp_f, input logic chk_sq,
                      input logic [30:0] exp_xf, input logic exp_ps,
                      input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      e_in     = e;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 32'(n), 32'(exp_lat));
      chk("f_out", 32'(f_out), 32'(exp_f));
      if (chk_sq) begin
         chk("sq_x_f", 32'(sq_x_f), 32'(exp_xf));
         chk("sq_polysel", 32'(sq_polysel), 32'(exp_ps));
      end
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      if (hold > 0) begin
         chk("held_valid", 32'(out_valid), 32'd1);
         chk("held_f", 32'(f_out), 32'(exp_f));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("ready_back", 32'(in_ready), 32'd1);
   endtask

   typedef struct {
      logic [30:0] e;
      int          lat;
      logic [23:0] f;
      logic        sq;
      logic [30:0] xf;
      logic        ps;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [30:0] e;
      logic [23:0] mf;
      int          ml;
      logic [30:0] mx;
      logic        mp;
      int          n;

      tbl[0] = '{31'h2000000,  7, 24'h200000, 1'b1, 31'h0,        1'b1};
      tbl[1] = '{31'h4000000,  6, 24'h2D4138, 1'b1, 31'h0,        1'b0};
      tbl[2] = '{31'h8000000,  5, 24'h400000, 1'b1, 31'h0,        1'b1};
      tbl[3] = '{31'h7FFFFFFF, 2, 24'hFFFFE0, 1'b1, 31'h7FFFFFFE, 1'b0};
      tbl[4] = '{31'h0,        0, 24'h000000, 1'b0, 31'h0,        1'b1};
      tbl[5] = '{31'h1,       32, 24'h00016A, 1'b1, 31'h0,        1'b0};
      tbl[6] = '{31'h6000000,  6, 24'h376CF0, 1'b1, 31'h40000000, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      e_in      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_f_out", 32'(f_out), 32'd0);
      chk("rst_sq_x_f", 32'(sq_x_f), 32'd0);
      chk("rst_polysel", 32'(sq_polysel), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         txn(tbl[i].e, tbl[i].lat, tbl[i].f, tbl[i].sq,
             tbl[i].xf, tbl[i].ps, i % 3);
      end

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) e = '0;
         else e = 31'($urandom) >> $urandom_range(0, 30);
         ref_model(e, mf, ml, mx, mp);
         txn(e, ml, mf, (e != '0), mx, mp, $urandom_range(0, 3));
      end

      // backpressure: output held, busy-time in_valid ignored
      txn(31'h6000000, 6, 24'h376CF0, 1'b1, 31'h40000000, 1'b0, 0);
      in_valid = 1'b1;
      e_in     = 31'h2000000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_latency", 32'(n), 32'd7);
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         e_in     = 31'h7FFFFFFF;
         @(posedge clk); #1;
         chk("bp_f_out", 32'(f_out), 32'h200000);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release", 32'(in_ready), 32'd1);
      txn(31'h8000000, 5, 24'h400000, 1'b1, 31'h0, 1'b1, 0);

      // reset in the middle of a long NORM phase
      txn(31'h6000000, 6, 24'h376CF0, 1'b1, 31'h40000000, 1'b0, 0);
      in_valid = 1'b1;
      e_in     = 31'h1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_sq_x_f", 32'(sq_x_f), 32'd0);
      chk("mid_rst_polysel", 32'(sq_polysel), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) n++;
      end
      chk("no_stale_valid", 32'(n), 32'd0);
      txn(31'h2000000, 7, 24'h200000, 1'b1, 31'h0, 1'b1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
